// File: rtl/pd_trace_buffer.sv
// Multi-channel pipeline trace capture: per-channel FIFOs of {pc, data, timestamp}
// merged onto one valid/ready output by a round-robin arbiter.
module pd_trace_buffer #(
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*32-1:0]     in_pc,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_ch,
  output logic [31:0]              out_pc,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [NUM_CH-1:0]        ovf,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 32 + DATA_W + TS_W;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [TS_W-1:0]   ts_q;
  logic [EW-1:0]     mem_q [NUM_CH][DEPTH];
  logic [AW-1:0]     wr_q  [NUM_CH];
  logic [AW-1:0]     rd_q  [NUM_CH];
  logic [AW:0]       cnt_q [NUM_CH];
  logic [AW:0]       cnt_d [NUM_CH];
  logic [CW-1:0]     grant_q, grant_d;
  logic              out_valid_q;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] want_s, push_s, pop_s, drop_s;
  logic              hold_s, found_s;

  // Push/pop decisions, next occupancy and round-robin re-grant on next-cycle occupancy
  always_comb begin
    int idx;
    idx     = 0;
    hold_s  = out_valid_q & ~out_ready;
    grant_d = grant_q;
    found_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      want_s[c] = en & in_valid[c];
      pop_s[c]  = out_valid_q & out_ready & (grant_q == CW'(c));
      push_s[c] = want_s[c] & ((cnt_q[c] != CNT_FULL) | pop_s[c]);
      drop_s[c] = want_s[c] & ~push_s[c];
      case ({push_s[c], pop_s[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
    if (!hold_s) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = (int'(grant_q) + i) % NUM_CH;
        if (!found_s && (cnt_d[idx[CW-1:0]] != '0)) begin
          grant_d = idx[CW-1:0];
          found_s = 1'b1;
        end else begin
          grant_d = grant_d;
        end
      end
    end else begin
      grant_d = grant_q;
    end
    // A drop in the same cycle as a clear wins, so the event is not lost
    ovf_d = (ovf_q & ~{NUM_CH{clr_ovf}}) | drop_s;
  end

  // Control state: timestamp, arbiter, sticky overflow, FIFO pointers and counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q        <= '0;
      grant_q     <= CW'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      ovf_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
      end
    end else begin
      ts_q        <= ts_q + TS_W'(1);
      grant_q     <= grant_d;
      out_valid_q <= (cnt_d[grant_d] != '0);
      ovf_q       <= ovf_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        if (push_s[c]) wr_q[c] <= wr_q[c] + AW'(1);
        if (pop_s[c])  rd_q[c] <= rd_q[c] + AW'(1);
      end
    end
  end

  // Record storage; contents are meaningless until counted in, so no reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_s[c]) begin
        mem_q[c][wr_q[c]] <= {in_pc[32*c +: 32], in_data[DATA_W*c +: DATA_W], ts_q};
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = grant_q;
  assign {out_pc, out_data, out_ts} = mem_q[grant_q][rd_q[grant_q]];
  assign ovf       = ovf_q;

endmodule

// File: doc/pd_trace_buffer.md
PD_TRACE_BUFFER -- requirements
Module: pd_trace_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of probe channels (F,D,E,M,W); range 1..8.
REQ-002 SHALL have parameter DEPTH, default 8, entries per channel FIFO; power of two, >=2.
REQ-003 SHALL have parameter DATA_W, default 32, width of captured probe data.
REQ-004 SHALL have parameter TS_W, default 16, timestamp width.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  input  1  capture enable.
REQ-008 SHALL have port in_valid  input  NUM_CH  per-channel probe event strobe.
REQ-009 SHALL have port in_pc  input  NUM_CH*32  per-channel PC; channel c at bits [32c+31:32c].
REQ-010 SHALL have port in_data  input  NUM_CH*DATA_W  per-channel data, same packing.
REQ-011 SHALL have port out_valid  output  1  record available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts record.
REQ-013 SHALL have port out_ch  output  max(1,clog2(NUM_CH))  source channel of record.
REQ-014 SHALL have port out_pc  output  32  record PC.
REQ-015 SHALL have port out_data  output  DATA_W  record data.
REQ-016 SHALL have port out_ts  output  TS_W  capture timestamp of record.
REQ-017 SHALL have port ovf  output  NUM_CH  sticky per-channel overflow flags.
REQ-018 SHALL have port clr_ovf  input  1  synchronous clear of all ovf bits.

Function
REQ-019 SHALL keep a free-running TS_W-bit cycle counter, +1 every cycle, wrapping 2^TS_W-1 -> 0.
REQ-020 SHALL give each channel an independent DEPTH-entry FIFO of {pc,data,ts}, ts = counter value in the push cycle.
REQ-021 SHALL push channel c when en=1, in_valid[c]=1, and (count_c<DEPTH or channel c is popped in the same cycle).
REQ-022 SHALL, when push is requested but refused as full, drop the event, leave FIFO unchanged, and set ovf[c]=1 next cycle.
REQ-023 SHALL keep ovf bits set until clr_ovf=1; a set and clear in the same cycle leaves the bit set.
REQ-024 SHALL ignore in_valid when en=0; buffered records keep draining regardless of en.
REQ-025 SHALL present on out_* the head of the granted channel; out_valid=1 iff that channel is non-empty.
REQ-026 SHALL pop the granted channel's head on a cycle with out_valid=1 and out_ready=1 (handshake).
REQ-027 SHALL hold grant and all out_* stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, after a handshake or while out_valid=0, re-grant round-robin: first non-empty channel searching from (last granted+1) mod NUM_CH upward.
REQ-029 SHALL make a record pushed in cycle t visible on out_* no earlier than cycle t+1 (no combinational in->out path).
REQ-030 SHALL preserve FIFO order within a channel; no cross-channel ordering beyond out_ts is guaranteed.
REQ-031 SHALL handle simultaneous push and pop on one channel with count unchanged, including at count=DEPTH.
REQ-032 SHALL wrap FIFO read/write pointers modulo DEPTH with no lost or duplicated entries.

Reset
REQ-033 SHALL on reset=1 immediately (asynchronously) empty all FIFOs, drive out_valid=0, ovf=0, timestamp=0, last-granted=NUM_CH-1 (so channel 0 is searched first).
REQ-034 SHALL discard all records and in-flight handshakes on reset mid-operation; out_ch/out_pc/out_data/out_ts are don't-care while out_valid=0.
REQ-035 SHALL begin capture on the first rising edge after reset deasserts; that cycle's ts=0.

Verification
REQ-036 Single push: reset release, en=1, ch2 in_valid one cycle with pc=0x100, data=0xAB at ts=3 -> next cycle out_valid=1, out_ch=2, out_pc=0x100, out_data=0xAB, out_ts=3.
REQ-037 Round-robin: ch0,ch1,ch4 push same cycle, out_ready=1 -> records emerge ch0, ch1, ch4 on three consecutive cycles.
REQ-038 Overflow: DEPTH=8, out_ready=0, ch1 pushes 9 events -> 8 buffered, 9th dropped, ovf=5'b00010; clr_ovf pulse -> ovf=0.
REQ-039 Backpressure: out_valid=1, out_ready=0 for 4 cycles while ch3 also fills -> out_* unchanged for 4 cycles, ch3 granted only after handshake.
REQ-040 Full with pop: ch0 full, out_ready=1 granting ch0, ch0 pushes same cycle -> push accepted, count stays 8, ovf[0]=0.
REQ-041 Reset mid-drain: 5 records pending, assert reset -> out_valid=0 same cycle; after release no stale record appears, out_ts of next capture counts from 0.
